mem_a_stage: RTL and testbench

//  First memory stage, directly downstream of execute. Registers execute's

---
 rtl/mem_a_stage_if.sv | 11 +
 rtl/mem_a_stage.sv | 212 +++++++++++++++++++++
 tb/tb_mem_a_stage.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_a_stage_if.sv
// Data-memory request bus between the mem_a stage (master) and data memory (slave).
interface mem_a_stage_if;
    logic        req;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        ready;

    modport master (output req, addr, we, wdata, input ready);
    modport slave  (input req, addr, we, wdata, output ready);
endinterface

// File: rtl/mem_a_stage.sv
// mem_a_stage: first memory stage after execute. Registers the execute bundle,
// issues the data-memory request and holds it until it is granted, and stalls
// upstream while the request is outstanding. A request that is never granted
// is aborted after TIMEOUT waiting cycles with a bus-error exception.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned word/half
// accesses with EXC_MISALIGN instead of issuing them.
module mem_a_stage #(
    parameter int unsigned TIMEOUT      = 64,
    parameter logic [7:0]  EXC_BUS_ERR  = 8'h06,
    parameter logic [7:0]  EXC_MISALIGN = 8'h05
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en_i,
    input  logic         halt_i,
    input  logic         bubble_i,
    input  logic [4:0]   opcode_i,
    input  logic [4:0]   tgt_1_i,
    input  logic [4:0]   tgt_2_i,
    input  logic [31:0]  result_1_i,
    input  logic [31:0]  result_2_i,
    input  logic [31:0]  addr_i,
    input  logic         mem_re_i,
    input  logic [3:0]   we_i,
    input  logic [31:0]  store_data_i,
    input  logic [7:0]   exc_i,
    input  logic [31:0]  pc_i,
    mem_a_stage_if.master dmem,
    output logic         stall_o,
    output logic         bubble_o,
    output logic [4:0]   tgt_1_o,
    output logic [4:0]   tgt_2_o,
    output logic [31:0]  result_1_o,
    output logic [31:0]  result_2_o,
    output logic [4:0]   opcode_o,
    output logic [7:0]   exc_o,
    output logic [31:0]  pc_o,
    output logic         is_load_o,
    output logic [1:0]   lane_o
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic        bubble;
        logic [4:0]  tgt_1;
        logic [4:0]  tgt_2;
        logic [31:0] result_1;
        logic [31:0] result_2;
        logic [4:0]  opcode;
        logic [7:0]  exc;
        logic [31:0] pc;
        logic        is_load;
        logic [1:0]  lane;
    } bundle_t;

    state_t      state_q, state_d;
    bundle_t     out_q, out_d;
    bundle_t     hold_q, hold_d;
    logic [31:0] h_addr_q, h_addr_d;
    logic [3:0]  h_we_q, h_we_d;
    logic [31:0] h_wdata_q, h_wdata_d;
    logic        h_halt_q, h_halt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic    access, misalign, issue, grant, timeout, flush;
    bundle_t in_b, bub_b;

    // Classify the incoming slot and build the bundle it would register as.
    always_comb begin
        access = !bubble_i && (exc_i == 8'h00) && (mem_re_i || (we_i != 4'h0));
`ifdef MEM_ALIGN_CHECK_EN
        misalign = access &&
                   (((opcode_i >= 5'd3) && (opcode_i <= 5'd5) && (addr_i[1:0] != 2'b00)) ||
                    ((opcode_i >= 5'd6) && (opcode_i <= 5'd8) && addr_i[0]));
`else
        misalign = 1'b0;
`endif
        issue = access && !misalign && !halt_i;

        in_b          = '0;
        in_b.bubble   = bubble_i || halt_i;
        // No writeback target leaves this stage for empty, faulting or flushed slots.
        in_b.tgt_1    = (bubble_i || halt_i || misalign || exc_i != 8'h00) ? 5'd0 : tgt_1_i;
        in_b.tgt_2    = (bubble_i || halt_i || misalign || exc_i != 8'h00) ? 5'd0 : tgt_2_i;
        in_b.result_1 = result_1_i;
        in_b.result_2 = result_2_i;
        in_b.opcode   = opcode_i;
        in_b.exc      = misalign ? EXC_MISALIGN : exc_i;
        in_b.pc       = pc_i;
        in_b.is_load  = mem_re_i && access && !misalign;
        in_b.lane     = (access && !misalign) ? addr_i[1:0] : 2'b00;

        bub_b         = '0;
        bub_b.bubble  = 1'b1;
    end

    // Request drive, stall and next-state selection.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        hold_d    = hold_q;
        h_addr_d  = h_addr_q;
        h_we_d    = h_we_q;
        h_wdata_d = h_wdata_q;
        h_halt_d  = h_halt_q;
        cnt_d     = cnt_q;
        dmem.req   = 1'b0;
        dmem.addr  = 32'h0;
        dmem.we    = 4'h0;
        dmem.wdata = 32'h0;
        stall_o   = 1'b0;
        // A frozen stage must not consume a grant, or the access would be lost.
        grant     = dmem.ready && clk_en_i;
        timeout   = (cnt_q == CW'(TIMEOUT - 1));
        flush     = h_halt_q || halt_i;

        case (state_q)
            IDLE: begin
                if (issue) begin
                    dmem.req   = 1'b1;
                    dmem.addr  = {addr_i[31:2], 2'b00};
                    dmem.we    = we_i;
                    dmem.wdata = store_data_i;
                end
                if (clk_en_i) begin
                    if (issue && !grant) begin
                        state_d   = WAIT;
                        hold_d    = in_b;
                        h_addr_d  = {addr_i[31:2], 2'b00};
                        h_we_d    = we_i;
                        h_wdata_d = store_data_i;
                        h_halt_d  = 1'b0;
                        cnt_d     = '0;
                        out_d     = bub_b;
                    end else begin
                        out_d = in_b;
                    end
                end
            end
            WAIT: begin
                dmem.req   = 1'b1;
                dmem.addr  = h_addr_q;
                dmem.we    = h_we_q;
                dmem.wdata = h_wdata_q;
                // Upstream may advance on the same cycle the access finishes.
                stall_o    = !(clk_en_i && (dmem.ready || timeout));
                if (clk_en_i) begin
                    h_halt_d = flush;
                    if (dmem.ready) begin
                        out_d = hold_q;
                        if (flush) begin
                            out_d.bubble = 1'b1;
                            out_d.tgt_1  = 5'd0;
                            out_d.tgt_2  = 5'd0;
                        end
                        state_d = IDLE;
                    end else if (timeout) begin
                        out_d        = hold_q;
                        out_d.exc    = EXC_BUS_ERR;
                        out_d.tgt_1  = 5'd0;
                        out_d.tgt_2  = 5'd0;
                        out_d.bubble = flush;
                        state_d      = IDLE;
                    end else begin
                        out_d = bub_b;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, output bundle and hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            out_q          <= '0;
            out_q.bubble   <= 1'b1;
            hold_q         <= '0;
            h_addr_q       <= 32'h0;
            h_we_q         <= 4'h0;
            h_wdata_q      <= 32'h0;
            h_halt_q       <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            out_q          <= out_d;
            hold_q         <= hold_d;
            h_addr_q       <= h_addr_d;
            h_we_q         <= h_we_d;
            h_wdata_q      <= h_wdata_d;
            h_halt_q       <= h_halt_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bubble_o   = out_q.bubble;
    assign tgt_1_o    = out_q.tgt_1;
    assign tgt_2_o    = out_q.tgt_2;
    assign result_1_o = out_q.result_1;
    assign result_2_o = out_q.result_2;
    assign opcode_o   = out_q.opcode;
    assign exc_o      = out_q.exc;
    assign pc_o       = out_q.pc;
    assign is_load_o  = out_q.is_load;
    assign lane_o     = out_q.lane;

endmodule

// File: tb/tb_mem_a_stage.sv
// Testbench for mem_a_stage: cycle model checked on every falling edge plus
// directed scenarios with hand-computed expectations.
module tb_mem_a_stage;
    localparam int TO = 8;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, clk_en = 1'b1, halt = 1'b0, bubble = 1'b1;
    logic [4:0]  opcode = '0, tgt1 = '0, tgt2 = '0;
    logic [31:0] res1 = '0, res2 = '0, addr = '0, wdata = '0, pc = '0;
    logic        re = 1'b0;
    logic [3:0]  we = '0;
    logic [7:0]  exc = '0;
    logic        stall, bub_o, ld_o;
    logic [4:0]  t1_o, t2_o, op_o;
    logic [31:0] r1_o, r2_o, pc_o;
    logic [7:0]  exc_o;
    logic [1:0]  lane_o;

    mem_a_stage_if bus();

    mem_a_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .clk_en_i(clk_en), .halt_i(halt), .bubble_i(bubble),
        .opcode_i(opcode), .tgt_1_i(tgt1), .tgt_2_i(tgt2), .result_1_i(res1),
        .result_2_i(res2), .addr_i(addr), .mem_re_i(re), .we_i(we),
        .store_data_i(wdata), .exc_i(exc), .pc_i(pc), .dmem(bus),
        .stall_o(stall), .bubble_o(bub_o), .tgt_1_o(t1_o), .tgt_2_o(t2_o),
        .result_1_o(r1_o), .result_2_o(r2_o), .opcode_o(op_o), .exc_o(exc_o),
        .pc_o(pc_o), .is_load_o(ld_o), .lane_o(lane_o)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0, total_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          bub;
        logic [4:0]  t1, t2, op;
        logic [31:0] r1, r2, pc;
        logic [7:0]  exc;
        bit          ld;
        logic [1:0]  lane;
    } bund_t;

    bund_t       m_out, m_held;
    bit          m_pend, m_flush;
    int          m_waited;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_we;

    function automatic bund_t empty_slot();
        bund_t b;
        b.bub = 1'b1; b.t1 = 0; b.t2 = 0; b.op = 0; b.r1 = 0; b.r2 = 0;
        b.pc = 0; b.exc = 0; b.ld = 1'b0; b.lane = 0;
        return b;
    endfunction

    // One check process: compare every falling edge, then advance the model to
    // what the next rising edge must produce.
    always @(negedge clk) begin
        bit acc, mis, iss, drop, e_req, e_stall;
        logic [31:0] e_addr, e_wdata;
        logic [3:0] e_we;
        bund_t nb;
        if (rst) begin
            m_out = empty_slot(); m_pend = 0; m_flush = 0; m_waited = 0;
        end else begin
            acc = !bubble && exc == 0 && (re || we != 0);
            mis = ALIGN && acc && ((opcode >= 3 && opcode <= 5 && addr[1:0] != 0) ||
                                   (opcode >= 6 && opcode <= 8 && addr[0]));
            iss = acc && !mis && !halt;
            if (m_pend) begin
                e_req = 1; e_addr = m_addr; e_we = m_we; e_wdata = m_wdata;
                e_stall = !(clk_en && (bus.ready || m_waited == TO - 1));
            end else begin
                e_req = iss; e_stall = 0;
                e_addr  = iss ? {addr[31:2], 2'b00} : 0;
                e_we    = iss ? we : 0;
                e_wdata = iss ? wdata : 0;
            end
            chk("m_req", bus.req, e_req);
            chk("m_addr", bus.addr, e_addr);
            chk("m_we", bus.we, e_we);
            chk("m_wdata", bus.wdata, e_wdata);
            chk("m_stall", stall, e_stall);
            chk("m_bubble", bub_o, m_out.bub);
            chk("m_tgt1", t1_o, m_out.t1);
            chk("m_tgt2", t2_o, m_out.t2);
            chk("m_res1", r1_o, m_out.r1);
            chk("m_res2", r2_o, m_out.r2);
            chk("m_op", op_o, m_out.op);
            chk("m_exc", exc_o, m_out.exc);
            chk("m_pc", pc_o, m_out.pc);
            chk("m_ld", ld_o, m_out.ld);
            chk("m_lane", lane_o, m_out.lane);
            if (clk_en) begin
                if (!m_pend) begin
                    drop = bubble || halt || mis || exc != 0;
                    nb.bub = bubble || halt;
                    nb.t1 = drop ? 5'd0 : tgt1; nb.t2 = drop ? 5'd0 : tgt2;
                    nb.r1 = res1; nb.r2 = res2; nb.op = opcode; nb.pc = pc;
                    nb.exc = mis ? 8'h05 : exc;
                    nb.ld = re && acc && !mis;
                    nb.lane = (acc && !mis) ? addr[1:0] : 2'b00;
                    if (iss && !bus.ready) begin
                        m_pend = 1; m_held = nb; m_waited = 0; m_flush = 0;
                        m_addr = {addr[31:2], 2'b00}; m_we = we; m_wdata = wdata;
                        m_out = empty_slot();
                    end else m_out = nb;
                end else begin
                    m_flush = m_flush || halt;
                    if (bus.ready || m_waited == TO - 1) begin
                        m_out = m_held;
                        if (!bus.ready) begin
                            m_out.exc = 8'h06; m_out.t1 = 0; m_out.t2 = 0;
                        end
                        if (m_flush) begin
                            m_out.bub = 1; m_out.t1 = 0; m_out.t2 = 0;
                        end
                        m_pend = 0;
                    end else begin
                        m_waited++;
                        m_out = empty_slot();
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(); @(posedge clk); #1; endtask

    task automatic idle_in();
        bubble = 1; re = 0; we = 0; exc = 0; halt = 0; opcode = 0;
        tgt1 = 0; tgt2 = 0; res1 = 0; res2 = 0; addr = 0; wdata = 0; pc = 0;
    endtask

    task automatic op_in(input logic [4:0] opc, input logic [31:0] a, input logic r,
                         input logic [3:0] w, input logic [31:0] d,
                         input logic [4:0] t, input logic [31:0] p);
        bubble = 0; opcode = opc; addr = a; re = r; we = w; wdata = d;
        tgt1 = t; tgt2 = 0; res1 = 32'h11; res2 = 32'h22; pc = p; exc = 0; halt = 0;
    endtask

    initial begin
        int n;
        bit done;
        bus.ready = 0;
        idle_in();
        tick(); tick();
        chk("rst_bubble", bub_o, 1);
        chk("rst_req", bus.req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_we", bus.we, 0);
        rst = 0;
        tick();

        // Non-memory op passes through with one cycle latency.
        op_in(5'd1, 32'h0, 0, 4'h0, 0, 5'd3, 32'h3C); res1 = 32'hABC;
        tick(); idle_in();
        chk("alu_res", r1_o, 32'hABC);
        chk("alu_tgt", t1_o, 3);

        // 1: load granted immediately.
        op_in(5'd3, 32'h100, 1, 4'h0, 0, 5'd5, 32'h40); bus.ready = 1;
        #1 chk("t1_req", bus.req, 1);
        tick(); idle_in(); bus.ready = 0;
        #1 chk("t1_bubble", bub_o, 0);
        chk("t1_tgt", t1_o, 5);
        chk("t1_stall", stall, 0);
        chk("t1_pc", pc_o, 32'h40);
        tick();

        // 2: store held for three waiting cycles, granted on the fourth.
        op_in(5'd3, 32'h204, 0, 4'hF, 32'hDEADBEEF, 5'd0, 32'h44);
        tick(); idle_in();
        for (int i = 0; i < 3; i++) begin
            #1 chk("t2_stall", stall, 1);
            chk("t2_addr", bus.addr, 32'h204);
            chk("t2_wdata", bus.wdata, 32'hDEADBEEF);
            tick();
        end
        bus.ready = 1;
        #1 chk("t2_stall_drop", stall, 0);
        tick(); bus.ready = 0;
        #1 chk("t2_bubble", bub_o, 0);
        chk("t2_pc", pc_o, 32'h44);
        tick();

        // 3: never granted -> bus error after TO waiting cycles.
        op_in(5'd3, 32'h300, 1, 4'h0, 0, 5'd7, 32'h48);
        n = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (bus.req) n++; else done = 1;
            if (!done) begin tick(); idle_in(); end
        end
        chk("t3_req_cycles", n, 9);
        chk("t3_exc", exc_o, 8'h06);
        chk("t3_bubble", bub_o, 0);
        chk("t3_tgt", t1_o, 0);
        tick();

        // 4: halt during wait, grant on the second waiting cycle.
        op_in(5'd3, 32'h208, 0, 4'h3, 32'h1234, 5'd9, 32'h4C);
        tick(); idle_in(); halt = 1;
        tick(); halt = 0; bus.ready = 1;
        #1 chk("t4_req", bus.req, 1);
        tick(); bus.ready = 0;
        #1 chk("t4_bubble", bub_o, 1);
        chk("t4_tgt", t1_o, 0);
        tick();

        // 5: misaligned word load.
        op_in(5'd3, 32'h102, 1, 4'h0, 0, 5'd4, 32'h50); bus.ready = 1;
        #1;
        if (ALIGN) chk("t5_req", bus.req, 0);
        else chk("t5_addr", bus.addr, 32'h100);
        tick(); idle_in(); bus.ready = 0;
        #1;
        if (ALIGN) chk("t5_exc", exc_o, 8'h05);
        else chk("t5_lane", lane_o, 2);
        tick();

        // Exception from execute: no request, target suppressed.
        op_in(5'd3, 32'h110, 1, 4'h0, 0, 5'd6, 32'h54); exc = 8'h03; bus.ready = 1;
        #1 chk("exc_req", bus.req, 0);
        tick(); idle_in(); bus.ready = 0;
        #1 chk("exc_out", exc_o, 8'h03);
        chk("exc_tgt", t1_o, 0);
        tick();

        // Halt in IDLE flushes the slot.
        op_in(5'd3, 32'h120, 1, 4'h0, 0, 5'd8, 32'h58); halt = 1; bus.ready = 1;
        #1 chk("hidle_req", bus.req, 0);
        tick(); idle_in(); bus.ready = 0;
        #1 chk("hidle_bubble", bub_o, 1);
        tick();

        // Clock enable low in WAIT ignores the grant.
        op_in(5'd6, 32'h130, 0, 4'h3, 32'h55AA, 5'd0, 32'h5C);
        tick(); idle_in(); clk_en = 0; bus.ready = 1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("cen_stall", stall, 1);
            chk("cen_req", bus.req, 1);
            tick();
        end
        clk_en = 1;
        tick(); bus.ready = 0;
        #1 chk("cen_bubble", bub_o, 0);
        chk("cen_pc", pc_o, 32'h5C);
        tick();

        // Grant on the timeout cycle wins.
        op_in(5'd3, 32'h140, 1, 4'h0, 0, 5'd2, 32'h60);
        tick(); idle_in();
        repeat (TO - 1) tick();
        bus.ready = 1;
        tick(); bus.ready = 0;
        #1 chk("gto_exc", exc_o, 0);
        chk("gto_tgt", t1_o, 2);
        tick();

        // Reset while waiting drops the request.
        op_in(5'd3, 32'h150, 0, 4'hF, 32'h77, 5'd0, 32'h64);
        tick(); idle_in(); rst = 1;
        tick(); rst = 0;
        #1 chk("rstw_req", bus.req, 0);
        chk("rstw_bubble", bub_o, 1);
        tick(); tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
